watch_set_ctrl: RTL

- Button-driven time-setting controller for the watch timekeeping block.
- On a mode press it snapshots the running time into shadow registers. It then lets the user step through the fields year, month, day, hour, minute and second, and increment the selected field with calendar-correct wrap.
- On a second mode press it commits the edited value to the timekeeper as bin_time with a one-cycle set_time pulse.
- If no button is pressed for a set time, the edit aborts and the timekeeper is left untouched.

---
 rtl/watch_set_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl
// Button-driven time-setting controller for the watch timekeeper.
// A mode press copies the running time into shadow registers. The user then
// selects a field and increments it, with calendar-correct wrap. A second
// mode press hands the edited time to the timekeeper through bin_time and a
// one-cycle set_time strobe. If no button is pressed for TIMEOUT_SEC seconds,
// the edit is abandoned and the timekeeper is left untouched.

module watch_set_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic [47:0] cur_time,
    output logic [47:0] bin_time,
    output logic        set_time,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic [47:0] shadow_time,
    output logic        blink
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_SEC);

    localparam logic [2:0] FIELD_YEAR   = 3'd0;
    localparam logic [2:0] FIELD_MONTH  = 3'd1;
    localparam logic [2:0] FIELD_DAY    = 3'd2;
    localparam logic [2:0] FIELD_HOUR   = 3'd3;
    localparam logic [2:0] FIELD_MINUTE = 3'd4;
    localparam logic [2:0] FIELD_SECOND = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]  sh_year;
    logic [7:0]  sh_month;
    logic [7:0]  sh_day;
    logic [7:0]  sh_hour;
    logic [7:0]  sh_minute;
    logic [7:0]  sh_second;
    logic [7:0]  nx_year;
    logic [7:0]  nx_month;
    logic [7:0]  nx_day;
    logic [7:0]  nx_hour;
    logic [7:0]  nx_minute;
    logic [7:0]  nx_second;

    logic [2:0]  field_q;
    logic [2:0]  field_next;
    logic [7:0]  idle_cnt;
    logic [7:0]  idle_cnt_next;
    logic [7:0]  idle_cnt_inc;
    logic        blink_q;
    logic        blink_next;
    logic [47:0] bin_q;
    logic [47:0] bin_next;

    logic        any_btn;
    logic        timeout_hit;
    logic        leap;
    logic        day_over;
    logic [7:0]  max_date;
    logic [7:0]  day_clamped;
    logic [7:0]  cur_month;
    logic [7:0]  cur_day;

    // A seconds tick with no button press counts toward the abort; reaching
    // the limit on this tick ends the edit. Any button in the same cycle wins.
    assign any_btn      = btn_mode | btn_sel | btn_inc;
    assign idle_cnt_inc = idle_cnt + 8'd1;
    assign timeout_hit  = clk1sec && !any_btn && (idle_cnt_inc == TIMEOUT_LIM);

    // Leap rule on the raw 8-bit year: divisible by 4 except 100 and 200,
    // with year 0 counting as divisible by 400.
    assign leap = ((sh_year[1:0] == 2'b00) && (sh_year != 8'd100) && (sh_year != 8'd200))
                  || (sh_year == 8'd0);

    // Month length for the shadow month/year; unexpected months fall back to 31.
    always_comb begin
        max_date = 8'd31;
        case (sh_month)
            8'd4, 8'd6, 8'd9, 8'd11: max_date = 8'd30;
            8'd2:                    max_date = leap ? 8'd29 : 8'd28;
            default:                 max_date = 8'd31;
        endcase
    end

    assign day_over    = (sh_day > max_date);
    assign day_clamped = day_over ? max_date : sh_day;

    // Snapshot sanitising so the shadow always starts from a legal month and day.
    assign cur_month = ((cur_time[39:32] == 8'd0) || (cur_time[39:32] > 8'd12)) ? 8'd1 : cur_time[39:32];
    assign cur_day   = (cur_time[31:24] == 8'd0) ? 8'd1 : cur_time[31:24];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: mode enters and leaves edit, timeout aborts, commit lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (btn_mode) begin
                    state_next = EDIT;
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    state_next = COMMIT;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: snapshot, field select, increment with wrap, day clamp and commit.
    always_comb begin
        nx_year       = sh_year;
        nx_month      = sh_month;
        nx_day        = sh_day;
        nx_hour       = sh_hour;
        nx_minute     = sh_minute;
        nx_second     = sh_second;
        field_next    = field_q;
        idle_cnt_next = idle_cnt;
        blink_next    = blink_q;
        bin_next      = bin_q;

        case (state)
            IDLE: begin
                if (btn_mode) begin
                    nx_year       = cur_time[47:40];
                    nx_month      = cur_month;
                    nx_day        = cur_day;
                    nx_hour       = cur_time[23:16];
                    nx_minute     = cur_time[15:8];
                    nx_second     = cur_time[7:0];
                    field_next    = FIELD_YEAR;
                    idle_cnt_next = 8'd0;
                    blink_next    = 1'b0;
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    // Loaded here so bin_time is already valid while set_time is high.
                    bin_next      = {sh_year, sh_month, day_clamped, sh_hour, sh_minute, sh_second};
                    idle_cnt_next = 8'd0;
                    blink_next    = 1'b0;
                end else if (btn_sel) begin
                    field_next    = (field_q >= FIELD_SECOND) ? FIELD_YEAR : (field_q + 3'd1);
                    idle_cnt_next = 8'd0;
                end else if (btn_inc) begin
                    idle_cnt_next = 8'd0;
                    case (field_q)
                        FIELD_YEAR:   nx_year   = (sh_year == 8'd255) ? 8'd1 : (sh_year + 8'd1);
                        FIELD_MONTH:  nx_month  = (sh_month >= 8'd12) ? 8'd1 : (sh_month + 8'd1);
                        FIELD_DAY:    nx_day    = (sh_day >= max_date) ? 8'd1 : (sh_day + 8'd1);
                        FIELD_HOUR:   nx_hour   = (sh_hour >= 8'd23) ? 8'd0 : (sh_hour + 8'd1);
                        FIELD_MINUTE: nx_minute = (sh_minute >= 8'd59) ? 8'd0 : (sh_minute + 8'd1);
                        FIELD_SECOND: nx_second = (sh_second >= 8'd59) ? 8'd0 : (sh_second + 8'd1);
                        default:      nx_year   = sh_year;
                    endcase
                end else if (clk1sec) begin
                    if (timeout_hit) begin
                        idle_cnt_next = 8'd0;
                        blink_next    = 1'b0;
                    end else begin
                        idle_cnt_next = idle_cnt_inc;
                        blink_next    = ~blink_q;
                    end
                end
                // An out-of-range day is pulled back before any day increment can act on it.
                if (day_over) begin
                    nx_day = max_date;
                end
            end
            default: begin
                blink_next = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_year   <= 8'd0;
            sh_month  <= 8'd0;
            sh_day    <= 8'd0;
            sh_hour   <= 8'd0;
            sh_minute <= 8'd0;
            sh_second <= 8'd0;
            field_q   <= 3'd0;
            idle_cnt  <= 8'd0;
            blink_q   <= 1'b0;
            bin_q     <= 48'd0;
        end else begin
            sh_year   <= nx_year;
            sh_month  <= nx_month;
            sh_day    <= nx_day;
            sh_hour   <= nx_hour;
            sh_minute <= nx_minute;
            sh_second <= nx_second;
            field_q   <= field_next;
            idle_cnt  <= idle_cnt_next;
            blink_q   <= blink_next;
            bin_q     <= bin_next;
        end
    end

    assign bin_time    = bin_q;
    assign set_time    = (state == COMMIT);
    assign edit_active = (state == EDIT);
    assign edit_field  = field_q;
    assign shadow_time = {sh_year, sh_month, sh_day, sh_hour, sh_minute, sh_second};
    assign blink       = blink_q;

endmodule
